issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Reservation station plus issue select; sits directly downstream of the dispatch stage.
- Accepts up to two renamed instructions per cycle and holds them in a 16-row reservation station.
- Captures source operands from functional-unit writeback broadcasts.
- Issues at most one ready instruction per functional unit per cycle, as registered outputs to the execute stage.

Parameters:
RS_DEPTH, 16, reservation-station rows (power of two; row index width log2(RS_DEPTH))
NUM_FU, 4, functional units, addressed by the 2-bit fu index
PREG_W, 6, physical register tag width (64 physical registers)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all rows
disp_valid_1 / disp_valid_2  input  1  dispatch slot valid
disp_op_j / disp_func3_j / disp_func7_j  input  7/3/7  decoded fields, j=1,2
disp_pd_j  input  6  destination physical register
disp_ps1_j / disp_ps2_j  input  6  source physical tags
disp_src1_data_j / disp_src2_data_j  input  32  source values, valid when the ready bit is set
disp_src1_ready_j / disp_src2_ready_j  input  1  source already available
disp_fu_j  input  2  target functional unit
disp_rob_j  input  4  ROB index
disp_stall  output  1  fewer than 2 free rows; registered
rs_free  output  5  free-row count, 0..16; registered
wb_valid_k  input  1  writeback broadcast from FU k, k=0..3
wb_pd_k  input  6  writeback tag
wb_data_k  input  32  writeback value
fu_busy  input  4  bit k high: FU k cannot accept an issue this cycle
iss_valid_k  output  1  issue to FU k, k=0..3
iss_op_k / iss_func3_k / iss_func7_k  output  7/3/7  instruction fields
iss_pd_k  output  6  destination tag
iss_src1_k / iss_src2_k  output  32  operand values
iss_rob_k  output  4  ROB index

Behaviour:
- Reset (rst_n low, asynchronous):
  - All rows in_use=0.
  - All iss_* outputs 0.
  - rs_free=16, disp_stall=0.
  - Reset mid-operation discards all rows.
- Row contents: in_use, op, func3, func7, pd, ps1, src1_data, src1_ready, ps2, src2_data, src2_ready, fu, rob.
- Allocation, at the rising edge:
  - A valid slot 1 takes the lowest-index free row.
  - A valid slot 2 takes the next lowest free row.
  - If slot 1 is invalid, slot 2 takes the lowest free row.
  - Rows freed by issue at the same edge are not reusable until the next edge.
- Dispatch while disp_stall is high is ignored (upstream contract); no row is written.
- Wakeup:
  - Each waiting source compares its tag against every valid wb_pd_k.
  - On a match, set ready and capture wb_data_k.
  - If several broadcasts match the same tag, the lowest k wins.
- Same-cycle bypass: a dispatched source that is not ready but matches a wb_pd_k at the same edge is written as ready with that data.
- Select (combinational on current row state):
  - For each FU k with fu_busy[k]=0, pick the lowest-index row with in_use, both sources ready, and fu==k.
  - At the edge: drive iss_valid_k=1 with the row's fields and clear that row's in_use.
  - If no row is selected, iss_valid_k=0. iss_* data holds its last value when invalid.
- Latency:
  - A row written at edge N is first selectable in cycle N; its earliest iss_valid is after edge N+1.
  - A row woken at edge N issues after edge N+1.
- rs_free and disp_stall are recomputed each edge from the post-update state; disp_stall = (rs_free < 2).
- flush:
  - Has priority over dispatch, wakeup and issue.
  - At the edge: all rows cleared, all iss_valid=0, rs_free=16, disp_stall=0.
- Full: with 16 rows in use, no allocation takes place and disp_stall=1.
- Simultaneous issue and dispatch: a freed row and a new row in the same cycle update the count net, e.g. 2 issued + 2 dispatched leaves rs_free unchanged.

Test Plan:
1. Reset, then one dispatch with ps1=3, ps2=4, both ready, fu=0, src1=5, src2=7, rob=2 -> two edges later iss_valid_0=1, iss_src1_0=5, iss_src2_0=7, iss_rob_0=2, rs_free=16.
2. Dispatch with src2 not ready (ps2=40), then wb_valid_1=1, wb_pd_1=40, wb_data_1=0xDEAD -> iss_valid_0 one edge after the wakeup, iss_src2_0=0xDEAD.
3. Dispatch on the same edge as a matching wb_pd_2 -> row written ready; issue follows on the next edge.
4. 16 dispatches with no ready sources -> rs_free=0, disp_stall=1; a further dispatch is ignored; one wakeup then issue -> rs_free=1, disp_stall still 1.
5. Two ready rows in rows 0 and 3, both fu=2, with fu_busy[2]=1 for 2 cycles -> no issue; after release row 0 issues first, row 3 on the next edge.
6. 6 rows in use plus flush concurrent with a dispatch -> next edge rs_free=16, all iss_valid=0, the dispatched instruction is absent.

Source files
------------

// File: rtl/issue_queue_if.sv
// Dispatch, writeback, busy and issue signals between the rename/dispatch stage,
// the functional units and the issue queue. Dispatch slot j=0 is slot 1, j=1 is slot 2.
interface issue_queue_if #(
    parameter int RS_DEPTH = 16,
    parameter int NUM_FU   = 4,
    parameter int PREG_W   = 6
);
    localparam int FU_W  = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    logic [1:0]                  disp_valid_i;
    logic [1:0][6:0]             disp_op_i;
    logic [1:0][2:0]             disp_func3_i;
    logic [1:0][6:0]             disp_func7_i;
    logic [1:0][PREG_W-1:0]      disp_pd_i;
    logic [1:0][PREG_W-1:0]      disp_ps1_i;
    logic [1:0][PREG_W-1:0]      disp_ps2_i;
    logic [1:0][31:0]            disp_src1_data_i;
    logic [1:0][31:0]            disp_src2_data_i;
    logic [1:0]                  disp_src1_ready_i;
    logic [1:0]                  disp_src2_ready_i;
    logic [1:0][FU_W-1:0]        disp_fu_i;
    logic [1:0][3:0]             disp_rob_i;
    logic                        disp_stall_o;
    logic [CNT_W-1:0]            rs_free_o;

    logic [NUM_FU-1:0]             wb_valid_i;
    logic [NUM_FU-1:0][PREG_W-1:0] wb_pd_i;
    logic [NUM_FU-1:0][31:0]       wb_data_i;
    logic [NUM_FU-1:0]             fu_busy_i;

    logic [NUM_FU-1:0]             iss_valid_o;
    logic [NUM_FU-1:0][6:0]        iss_op_o;
    logic [NUM_FU-1:0][2:0]        iss_func3_o;
    logic [NUM_FU-1:0][6:0]        iss_func7_o;
    logic [NUM_FU-1:0][PREG_W-1:0] iss_pd_o;
    logic [NUM_FU-1:0][31:0]       iss_src1_o;
    logic [NUM_FU-1:0][31:0]       iss_src2_o;
    logic [NUM_FU-1:0][3:0]        iss_rob_o;

    modport master (
        output disp_valid_i, disp_op_i, disp_func3_i, disp_func7_i, disp_pd_i,
               disp_ps1_i, disp_ps2_i, disp_src1_data_i, disp_src2_data_i,
               disp_src1_ready_i, disp_src2_ready_i, disp_fu_i, disp_rob_i,
               wb_valid_i, wb_pd_i, wb_data_i, fu_busy_i,
        input  disp_stall_o, rs_free_o, iss_valid_o, iss_op_o, iss_func3_o,
               iss_func7_o, iss_pd_o, iss_src1_o, iss_src2_o, iss_rob_o
    );

    modport slave (
        input  disp_valid_i, disp_op_i, disp_func3_i, disp_func7_i, disp_pd_i,
               disp_ps1_i, disp_ps2_i, disp_src1_data_i, disp_src2_data_i,
               disp_src1_ready_i, disp_src2_ready_i, disp_fu_i, disp_rob_i,
               wb_valid_i, wb_pd_i, wb_data_i, fu_busy_i,
        output disp_stall_o, rs_free_o, iss_valid_o, iss_op_o, iss_func3_o,
               iss_func7_o, iss_pd_o, iss_src1_o, iss_src2_o, iss_rob_o
    );
endinterface

// File: rtl/issue_queue.sv
// Reservation station with writeback wakeup and per-FU lowest-index issue select.
// Two dispatches per cycle in, at most one registered issue per functional unit out.
module issue_queue #(
    parameter int RS_DEPTH = 16,
    parameter int NUM_FU   = 4,
    parameter int PREG_W   = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    issue_queue_if.slave  bus
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int FU_W  = $clog2(NUM_FU);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              inUse;
        logic [6:0]        op;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] ps1;
        logic [31:0]       src1Data;
        logic              src1Ready;
        logic [PREG_W-1:0] ps2;
        logic [31:0]       src2Data;
        logic              src2Ready;
        logic [FU_W-1:0]   fu;
        logic [3:0]        rob;
    } row_t;

    row_t             rows_q [RS_DEPTH];
    row_t             rows_d [RS_DEPTH];
    row_t             slotRow [2];
    logic [CNT_W-1:0] rsFree_q, rsFree_d;
    logic             stall_q, stall_d;

    logic [NUM_FU-1:0]            selValid;
    logic [NUM_FU-1:0][IDX_W-1:0] selIdx;
    logic                         free1Found, free2Found;
    logic [IDX_W-1:0]             free1, free2;
    logic [CNT_W-1:0]             usedCnt;

    logic [NUM_FU-1:0]      issValid_q;
    logic [NUM_FU-1:0][6:0] issOp_q, issFunc7_q;
    logic [NUM_FU-1:0][2:0] issFunc3_q;
    logic [NUM_FU-1:0][PREG_W-1:0] issPd_q;
    logic [NUM_FU-1:0][31:0] issSrc1_q, issSrc2_q;
    logic [NUM_FU-1:0][3:0] issRob_q;

    // Returns {ready, data}; iterating downward lets the lowest matching FU win.
    function automatic logic [32:0] wake(input logic rdy, input logic [PREG_W-1:0] tag,
                                         input logic [31:0] data);
        logic [32:0] res;
        res = {rdy, data};
        if (!rdy) begin
            for (int k = NUM_FU - 1; k >= 0; k--) begin
                if (bus.wb_valid_i[k] && bus.wb_pd_i[k] == tag) begin
                    res = {1'b1, bus.wb_data_i[k]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        selValid = '0;
        selIdx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (!selValid[k] && !bus.fu_busy_i[k] && rows_q[i].inUse &&
                    rows_q[i].src1Ready && rows_q[i].src2Ready && rows_q[i].fu == FU_W'(k)) begin
                    selValid[k] = 1'b1;
                    selIdx[k]   = IDX_W'(i);
                end
            end
        end
    end

    // Free rows come from the pre-issue state so issued rows are not reused this edge.
    always_comb begin
        free1Found = 1'b0;
        free2Found = 1'b0;
        free1      = '0;
        free2      = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!rows_q[i].inUse) begin
                if (!free1Found) begin
                    free1Found = 1'b1;
                    free1      = IDX_W'(i);
                end else if (!free2Found) begin
                    free2Found = 1'b1;
                    free2      = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            slotRow[j].inUse = 1'b1;
            slotRow[j].op    = bus.disp_op_i[j];
            slotRow[j].func3 = bus.disp_func3_i[j];
            slotRow[j].func7 = bus.disp_func7_i[j];
            slotRow[j].pd    = bus.disp_pd_i[j];
            slotRow[j].ps1   = bus.disp_ps1_i[j];
            slotRow[j].ps2   = bus.disp_ps2_i[j];
            slotRow[j].fu    = bus.disp_fu_i[j];
            slotRow[j].rob   = bus.disp_rob_i[j];
            {slotRow[j].src1Ready, slotRow[j].src1Data} =
                wake(bus.disp_src1_ready_i[j], bus.disp_ps1_i[j], bus.disp_src1_data_i[j]);
            {slotRow[j].src2Ready, slotRow[j].src2Data} =
                wake(bus.disp_src2_ready_i[j], bus.disp_ps2_i[j], bus.disp_src2_data_i[j]);
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            rows_d[i] = rows_q[i];
            if (rows_q[i].inUse) begin
                {rows_d[i].src1Ready, rows_d[i].src1Data} =
                    wake(rows_q[i].src1Ready, rows_q[i].ps1, rows_q[i].src1Data);
                {rows_d[i].src2Ready, rows_d[i].src2Data} =
                    wake(rows_q[i].src2Ready, rows_q[i].ps2, rows_q[i].src2Data);
            end
        end
        for (int k = 0; k < NUM_FU; k++) begin
            if (selValid[k]) begin
                rows_d[selIdx[k]].inUse = 1'b0;
            end
        end
        if (!stall_q) begin
            if (bus.disp_valid_i[0] && free1Found) begin
                rows_d[free1] = slotRow[0];
            end
            if (bus.disp_valid_i[1]) begin
                if (bus.disp_valid_i[0]) begin
                    if (free2Found) rows_d[free2] = slotRow[1];
                end else if (free1Found) begin
                    rows_d[free1] = slotRow[1];
                end
            end
        end
        if (flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rows_d[i].inUse = 1'b0;
            end
        end
        usedCnt = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            usedCnt = usedCnt + CNT_W'(rows_d[i].inUse);
        end
        rsFree_d = CNT_W'(RS_DEPTH) - usedCnt;
        stall_d  = rsFree_d < CNT_W'(2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rows_q[i] <= '0;
            end
            rsFree_q <= CNT_W'(RS_DEPTH);
            stall_q  <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rows_q[i] <= rows_d[i];
            end
            rsFree_q <= rsFree_d;
            stall_q  <= stall_d;
        end
    end

    // Issue payload holds its last value whenever the FU sees no valid issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issValid_q <= '0;
            issOp_q    <= '0;
            issFunc3_q <= '0;
            issFunc7_q <= '0;
            issPd_q    <= '0;
            issSrc1_q  <= '0;
            issSrc2_q  <= '0;
            issRob_q   <= '0;
        end else if (flush_i) begin
            issValid_q <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                issValid_q[k] <= selValid[k];
                if (selValid[k]) begin
                    issOp_q[k]    <= rows_q[selIdx[k]].op;
                    issFunc3_q[k] <= rows_q[selIdx[k]].func3;
                    issFunc7_q[k] <= rows_q[selIdx[k]].func7;
                    issPd_q[k]    <= rows_q[selIdx[k]].pd;
                    issSrc1_q[k]  <= rows_q[selIdx[k]].src1Data;
                    issSrc2_q[k]  <= rows_q[selIdx[k]].src2Data;
                    issRob_q[k]   <= rows_q[selIdx[k]].rob;
                end
            end
        end
    end

    assign bus.disp_stall_o = stall_q;
    assign bus.rs_free_o    = rsFree_q;
    assign bus.iss_valid_o  = issValid_q;
    assign bus.iss_op_o     = issOp_q;
    assign bus.iss_func3_o  = issFunc3_q;
    assign bus.iss_func7_o  = issFunc7_q;
    assign bus.iss_pd_o     = issPd_q;
    assign bus.iss_src1_o   = issSrc1_q;
    assign bus.iss_src2_o   = issSrc2_q;
    assign bus.iss_rob_o    = issRob_q;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: allocation order, wakeup, bypass, busy FUs,
// full queue, flush, net free-count and asynchronous reset.
module tb_issue_queue;
    logic clk;
    logic rst_n;
    logic flush;
    int   passCount;
    int   checkCount;

    issue_queue_if bus ();

    issue_queue dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        bus.disp_valid_i      = '0;
        bus.disp_op_i         = '0;
        bus.disp_func3_i      = '0;
        bus.disp_func7_i      = '0;
        bus.disp_pd_i         = '0;
        bus.disp_ps1_i        = '0;
        bus.disp_ps2_i        = '0;
        bus.disp_src1_data_i  = '0;
        bus.disp_src2_data_i  = '0;
        bus.disp_src1_ready_i = '0;
        bus.disp_src2_ready_i = '0;
        bus.disp_fu_i         = '0;
        bus.disp_rob_i        = '0;
        bus.wb_valid_i        = '0;
        bus.wb_pd_i           = '0;
        bus.wb_data_i         = '0;
    endtask

    // Loads one dispatch slot; pd is derived from rob so it can be checked too.
    task automatic applyStimulus(input int slot, input logic [5:0] ps1, input logic [5:0] ps2,
                                 input logic r1, input logic r2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [1:0] fu, input logic [3:0] rob);
        bus.disp_valid_i[slot]      = 1'b1;
        bus.disp_op_i[slot]         = 7'h33;
        bus.disp_func3_i[slot]      = 3'd5;
        bus.disp_func7_i[slot]      = 7'h20;
        bus.disp_pd_i[slot]         = {2'b01, rob};
        bus.disp_ps1_i[slot]        = ps1;
        bus.disp_ps2_i[slot]        = ps2;
        bus.disp_src1_ready_i[slot] = r1;
        bus.disp_src2_ready_i[slot] = r2;
        bus.disp_src1_data_i[slot]  = d1;
        bus.disp_src2_data_i[slot]  = d2;
        bus.disp_fu_i[slot]         = fu;
        bus.disp_rob_i[slot]        = rob;
    endtask

    task automatic setWb(input int k, input logic [5:0] pd, input logic [31:0] data);
        bus.wb_valid_i[k] = 1'b1;
        bus.wb_pd_i[k]    = pd;
        bus.wb_data_i[k]  = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        bus.fu_busy_i = '0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rs_free", 32'(bus.rs_free_o), 32'd16);
        checkOutput("reset_stall", 32'(bus.disp_stall_o), 32'd0);
        checkOutput("reset_iss_valid", 32'(bus.iss_valid_o), 32'd0);
        checkOutput("reset_iss_src1_0", bus.iss_src1_o[0], 32'd0);
        rst_n = 1'b1;

        $display("[TB] basic dispatch and issue");
        applyStimulus(0, 6'd3, 6'd4, 1'b1, 1'b1, 32'd5, 32'd7, 2'd0, 4'd2);
        tick();
        clearInputs();
        checkOutput("t1_rs_free_after_write", 32'(bus.rs_free_o), 32'd15);
        checkOutput("t1_no_issue_yet", 32'(bus.iss_valid_o), 32'd0);
        tick();
        checkOutput("t1_iss_valid", 32'(bus.iss_valid_o), 32'b0001);
        checkOutput("t1_iss_src1", bus.iss_src1_o[0], 32'd5);
        checkOutput("t1_iss_src2", bus.iss_src2_o[0], 32'd7);
        checkOutput("t1_iss_rob", 32'(bus.iss_rob_o[0]), 32'd2);
        checkOutput("t1_iss_pd", 32'(bus.iss_pd_o[0]), 32'h12);
        checkOutput("t1_iss_op", 32'(bus.iss_op_o[0]), 32'h33);
        checkOutput("t1_rs_free", 32'(bus.rs_free_o), 32'd16);
        tick();
        checkOutput("t1_valid_drops", 32'(bus.iss_valid_o), 32'd0);
        checkOutput("t1_data_holds", bus.iss_src1_o[0], 32'd5);

        $display("[TB] wakeup from writeback");
        applyStimulus(0, 6'd1, 6'd40, 1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 4'd3);
        tick();
        clearInputs();
        checkOutput("t2_waiting", 32'(bus.iss_valid_o), 32'd0);
        setWb(1, 6'd40, 32'hDEAD);
        tick();
        clearInputs();
        checkOutput("t2_not_same_edge", 32'(bus.iss_valid_o), 32'd0);
        tick();
        checkOutput("t2_iss_valid", 32'(bus.iss_valid_o), 32'b0001);
        checkOutput("t2_iss_src2", bus.iss_src2_o[0], 32'hDEAD);
        checkOutput("t2_iss_src1", bus.iss_src1_o[0], 32'h11);
        checkOutput("t2_iss_rob", 32'(bus.iss_rob_o[0]), 32'd3);

        $display("[TB] same-edge bypass, lowest FU wins");
        applyStimulus(0, 6'd20, 6'd21, 1'b0, 1'b1, 32'h0, 32'h77, 2'd1, 4'd4);
        setWb(2, 6'd20, 32'h1234);
        setWb(3, 6'd20, 32'h9999);
        tick();
        clearInputs();
        checkOutput("t3_no_issue_yet", 32'(bus.iss_valid_o), 32'd0);
        tick();
        checkOutput("t3_iss_valid", 32'(bus.iss_valid_o), 32'b0010);
        checkOutput("t3_bypass_src1", bus.iss_src1_o[1], 32'h1234);
        checkOutput("t3_src2", bus.iss_src2_o[1], 32'h77);
        checkOutput("t3_rs_free", 32'(bus.rs_free_o), 32'd16);

        $display("[TB] fill all rows");
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 6'(32 + 2 * c), 6'd0, 1'b0, 1'b1, 32'h0, 32'(c), 2'd3, 4'(2 * c));
            applyStimulus(1, 6'(33 + 2 * c), 6'd0, 1'b0, 1'b1, 32'h0, 32'(c), 2'd3, 4'(2 * c + 1));
            tick();
            clearInputs();
            if (c == 6) begin
                checkOutput("t4_rs_free_two_left", 32'(bus.rs_free_o), 32'd2);
                checkOutput("t4_no_stall_two_left", 32'(bus.disp_stall_o), 32'd0);
            end
        end
        checkOutput("t4_rs_free_full", 32'(bus.rs_free_o), 32'd0);
        checkOutput("t4_stall_full", 32'(bus.disp_stall_o), 32'd1);
        applyStimulus(0, 6'd0, 6'd0, 1'b1, 1'b1, 32'hBAD, 32'hBAD, 2'd3, 4'hE);
        tick();
        clearInputs();
        checkOutput("t4_ignored_free", 32'(bus.rs_free_o), 32'd0);
        checkOutput("t4_ignored_no_issue", 32'(bus.iss_valid_o), 32'd0);
        setWb(0, 6'd37, 32'h55);
        tick();
        clearInputs();
        checkOutput("t4_wake_free", 32'(bus.rs_free_o), 32'd0);
        tick();
        checkOutput("t4_iss_valid", 32'(bus.iss_valid_o), 32'b1000);
        checkOutput("t4_iss_rob_row5", 32'(bus.iss_rob_o[3]), 32'd5);
        checkOutput("t4_iss_src1", bus.iss_src1_o[3], 32'h55);
        checkOutput("t4_rs_free_one", 32'(bus.rs_free_o), 32'd1);
        checkOutput("t4_stall_one", 32'(bus.disp_stall_o), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t4_flush_free", 32'(bus.rs_free_o), 32'd16);
        checkOutput("t4_flush_stall", 32'(bus.disp_stall_o), 32'd0);

        $display("[TB] busy functional unit");
        bus.fu_busy_i = 4'b0100;
        applyStimulus(0, 6'd0, 6'd0, 1'b1, 1'b1, 32'h80, 32'h0, 2'd2, 4'd8);
        applyStimulus(1, 6'd45, 6'd0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd1, 4'd10);
        tick();
        clearInputs();
        applyStimulus(0, 6'd46, 6'd0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd1, 4'd11);
        applyStimulus(1, 6'd0, 6'd0, 1'b1, 1'b1, 32'h90, 32'h0, 2'd2, 4'd9);
        tick();
        clearInputs();
        checkOutput("t5_busy_1", 32'(bus.iss_valid_o), 32'd0);
        tick();
        checkOutput("t5_busy_2", 32'(bus.iss_valid_o), 32'd0);
        bus.fu_busy_i = '0;
        tick();
        checkOutput("t5_first_valid", 32'(bus.iss_valid_o), 32'b0100);
        checkOutput("t5_first_row0", 32'(bus.iss_rob_o[2]), 32'd8);
        tick();
        checkOutput("t5_second_valid", 32'(bus.iss_valid_o), 32'b0100);
        checkOutput("t5_second_row3", 32'(bus.iss_rob_o[2]), 32'd9);
        checkOutput("t5_second_src1", bus.iss_src1_o[2], 32'h90);
        tick();
        checkOutput("t5_idle", 32'(bus.iss_valid_o), 32'd0);
        checkOutput("t5_rs_free", 32'(bus.rs_free_o), 32'd14);

        $display("[TB] flush with concurrent dispatch");
        applyStimulus(0, 6'd50, 6'd0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 4'd12);
        applyStimulus(1, 6'd51, 6'd0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 4'd13);
        tick();
        clearInputs();
        applyStimulus(0, 6'd52, 6'd0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 4'd14);
        applyStimulus(1, 6'd53, 6'd0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 4'd15);
        tick();
        clearInputs();
        checkOutput("t6_six_used", 32'(bus.rs_free_o), 32'd10);
        applyStimulus(0, 6'd0, 6'd0, 1'b1, 1'b1, 32'hAA, 32'hAA, 2'd0, 4'hA);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clearInputs();
        checkOutput("t6_flush_free", 32'(bus.rs_free_o), 32'd16);
        checkOutput("t6_flush_stall", 32'(bus.disp_stall_o), 32'd0);
        checkOutput("t6_flush_valid", 32'(bus.iss_valid_o), 32'd0);
        tick();
        checkOutput("t6_dispatch_absent", 32'(bus.iss_valid_o), 32'd0);
        checkOutput("t6_still_empty", 32'(bus.rs_free_o), 32'd16);

        $display("[TB] issue and dispatch in the same cycle");
        applyStimulus(0, 6'd0, 6'd0, 1'b1, 1'b1, 32'h1, 32'h0, 2'd0, 4'd1);
        applyStimulus(1, 6'd0, 6'd0, 1'b1, 1'b1, 32'h2, 32'h0, 2'd1, 4'd2);
        tick();
        clearInputs();
        checkOutput("t7_two_used", 32'(bus.rs_free_o), 32'd14);
        applyStimulus(0, 6'd0, 6'd0, 1'b1, 1'b1, 32'h3, 32'h0, 2'd0, 4'd3);
        applyStimulus(1, 6'd0, 6'd0, 1'b1, 1'b1, 32'h4, 32'h0, 2'd1, 4'd4);
        tick();
        clearInputs();
        checkOutput("t7_issue_valid", 32'(bus.iss_valid_o), 32'b0011);
        checkOutput("t7_fu0_rob", 32'(bus.iss_rob_o[0]), 32'd1);
        checkOutput("t7_fu1_rob", 32'(bus.iss_rob_o[1]), 32'd2);
        checkOutput("t7_net_free", 32'(bus.rs_free_o), 32'd14);
        tick();
        checkOutput("t7_fu0_rob_next", 32'(bus.iss_rob_o[0]), 32'd3);
        checkOutput("t7_fu1_rob_next", 32'(bus.iss_rob_o[1]), 32'd4);
        checkOutput("t7_empty", 32'(bus.rs_free_o), 32'd16);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(0, 6'd60, 6'd0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 4'd6);
        tick();
        clearInputs();
        checkOutput("t8_one_used", 32'(bus.rs_free_o), 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t8_async_free", 32'(bus.rs_free_o), 32'd16);
        checkOutput("t8_async_stall", 32'(bus.disp_stall_o), 32'd0);
        rst_n = 1'b1;
        setWb(0, 6'd60, 32'h60);
        tick();
        clearInputs();
        tick();
        checkOutput("t8_row_discarded", 32'(bus.iss_valid_o), 32'd0);
        checkOutput("t8_free_after", 32'(bus.rs_free_o), 32'd16);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
